mat_loader: RTL
===============

MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 SHALL have parameter I, default 4: rows of matrix A.
REQ-002 SHALL have parameter J, default 4: columns of A and rows of B.
REQ-003 SHALL have parameter K, default 4: columns of matrix B.
REQ-004 SHALL have parameter EXP_WIDTH, default 8, and MAN_WIDTH, default 23; element width FW = 1+EXP_WIDTH+MAN_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port clear, input, 1 bit: synchronous restart of loading.
REQ-008 SHALL have port in_data, input, FW bits: one float element.
REQ-009 SHALL have port in_valid, input, 1 bit, and in_ready, output, 1 bit: input handshake.
REQ-010 SHALL have port mat1, output, I*J*FW bits: flattened A, element (i,j) at index i*J+j, bits [(idx+1)*FW-1 : idx*FW].
REQ-011 SHALL have port mat2, output, J*K*FW bits: flattened B, element (j,k) at index j*K+k, same packing.
REQ-012 SHALL have port out_valid, output, 1 bit, and out_ready, input, 1 bit: output handshake to the downstream multiplier.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than LOAD_A with a zero count.

Function
REQ-014 SHALL implement states LOAD_A, LOAD_B and FULL.
REQ-015 SHALL accept an element only on a cycle with in_valid && in_ready.
REQ-016 SHALL drive in_ready=1 in LOAD_A and LOAD_B, and in_ready=0 in FULL.
REQ-017 SHALL stream elements row-major: the first I*J accepted words go to A; the next J*K words go to B.
REQ-018 SHALL hold a single element counter that wraps to 0 at each matrix boundary.
- LOAD_A to LOAD_B on acceptance of A word I*J-1.
- LOAD_B to FULL on acceptance of B word J*K-1.
REQ-019 SHALL assert out_valid only in FULL, starting the cycle after the last B word is accepted.
REQ-020 SHALL keep mat1 and mat2 bit-stable while out_valid=1.
REQ-021 SHALL, on out_valid && out_ready, return to LOAD_A with count 0; in_ready=1 on the next cycle, so the minimum turnaround is one bubble cycle.
REQ-022 SHALL tolerate out_ready held high before out_valid: the transfer completes in the first FULL cycle.
REQ-023 SHALL, on clear=1, go to LOAD_A with count 0 on the next edge.
- clear overrides a simultaneous input or output handshake; neither is counted.
- Buffer contents are left unchanged.
REQ-024 SHALL not alter buffer contents except by writing accepted words.
REQ-025 SHALL treat element values as opaque bits: no rounding, reordering or normalisation.

Reset
REQ-026 SHALL, while rst=1, force the following immediately and independently of clk:
- state LOAD_A and count 0;
- in_ready=1, out_valid=0, busy=0;
- mat1 and mat2 all zero.
REQ-027 SHALL discard a partially loaded pair when rst asserts mid-load; the first word after deassertion is A(0,0).

Configuration
REQ-028 SHALL, with macro MAT_LOADER_NAN_FLAG_EN defined, add output nan_seen, 1 bit.
- Sets when an accepted word has exponent all ones and a nonzero mantissa.
- Sticky until the output handshake, clear or rst; valid alongside out_valid.
REQ-029 SHALL, without MAT_LOADER_NAN_FLAG_EN, omit the nan_seen port and its logic entirely.

Structure
REQ-030 SHALL place the state enum and the width helper constants in the shared mat package: FW, I*J*FW and J*K*FW, with FW consistent with the FLOAT_WIDTH and MAT_WIDTH macros.
REQ-031 SHALL be a single module with no sub-modules; the NaN detector is an inline function.

Verification
REQ-032 SHALL cover: I=J=K=4, stream 32 words 0x3F800000+n (n=0..31) with in_valid always high and out_ready=1.
- A(1,2) = 0x3F800006; B(3,3) = 0x3F80001F.
- out_valid high exactly 1 cycle after word 31; in_ready back to 1 one cycle later.
REQ-033 SHALL cover backpressure: out_ready=0 for 20 cycles after FULL.
- out_valid stays 1, in_ready stays 0, mat1/mat2 unchanged.
- A stray in_valid pulse during this time is ignored.
REQ-034 SHALL cover random in_valid gaps (50% duty) over 3 back-to-back pairs; every element lands at the index given by its arrival order.
REQ-035 SHALL cover clear asserted on the same cycle as A word 15.
- That word is not stored; LOAD_B is never entered.
- The next word is stored at A(0,0).
REQ-036 SHALL cover rst asserted asynchronously mid-LOAD_B.
- out_valid, mat1 and mat2 are zero before the next clk edge.
- Reload then completes normally.
REQ-037 SHALL cover, with MAT_LOADER_NAN_FLAG_EN defined: word 0x7FC00000 at B(0,1) sets nan_seen; 0x7F800000 (infinity) alone does not set it.

Source files
------------

// File: rtl/mat_loader_pkg.sv
// ============================================================================
// Module  : mat_loader_pkg
// Purpose : Shared definitions for the matrix loader. This package holds the
//           loader state enum, the default element and matrix widths, and the
//           helper functions that derive widths from the float format.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FLOAT_WIDTH
`define FLOAT_WIDTH 32
`endif

`ifndef MAT_WIDTH
`define MAT_WIDTH 512
`endif

package mat_loader_pkg;

  // Loader phases: filling A, filling B, holding a complete pair
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } mat_state_t;

  // Default-configuration widths (4x4 matrices of single-precision floats)
  localparam int FW     = `FLOAT_WIDTH;
  localparam int MAT1_W = `MAT_WIDTH;
  localparam int MAT2_W = `MAT_WIDTH;

  // Width of one element: sign + exponent + mantissa
  function automatic int elem_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Width of a flattened rows x cols matrix of fw-bit elements
  function automatic int mat_width(input int rows, input int cols, input int fw);
    return rows * cols * fw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mat_loader.sv
// ============================================================================
// Module  : mat_loader
// Purpose : Streams float words row-major into matrix A (I x J) and then
//           matrix B (J x K), and presents the pair to a downstream multiplier
//           through a valid/ready handshake.
// Options : MAT_LOADER_NAN_FLAG_EN adds the sticky nan_seen output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_loader
  import mat_loader_pkg::*;
#(
  parameter int I         = 4,
  parameter int J         = 4,
  parameter int K         = 4,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clear,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]               in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [I*J*(EXP_WIDTH+MAN_WIDTH+1)-1:0]     mat1,
  output logic [J*K*(EXP_WIDTH+MAN_WIDTH+1)-1:0]     mat2,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       busy
`ifdef MAT_LOADER_NAN_FLAG_EN
  ,
  output logic                                       nan_seen
`endif
);

  localparam int c_fw     = elem_width(EXP_WIDTH, MAN_WIDTH);
  localparam int c_mat1_w = mat_width(I, J, c_fw);
  localparam int c_mat2_w = mat_width(J, K, c_fw);
  localparam int c_max    = (I * J > J * K) ? I * J : J * K;
  localparam int c_cw     = (c_max > 1) ? $clog2(c_max) : 1;

  localparam logic [c_cw-1:0] c_last_a = c_cw'(I * J - 1);
  localparam logic [c_cw-1:0] c_last_b = c_cw'(J * K - 1);
  localparam logic [c_cw-1:0] c_one    = c_cw'(1);

  mat_state_t          r_state;
  logic [c_cw-1:0]     r_count;
  logic [c_mat1_w-1:0] r_mat1;
  logic [c_mat2_w-1:0] r_mat2;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic w_accept;
  logic w_handshake;

  // in_ready is only high in the load states, so it alone qualifies a word
  assign w_accept    = in_valid && r_in_ready;
  assign w_handshake = r_out_valid && out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign mat1      = r_mat1;
  assign mat2      = r_mat2;

  // Loader FSM: one shared element counter, registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LOAD_A;
      r_count     <= '0;
      r_mat1      <= '0;
      r_mat2      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear) begin
      // Restart loading; buffers keep whatever they held
      r_state     <= LOAD_A;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_accept) begin
            r_mat1[int'(r_count)*c_fw +: c_fw] <= in_data;
            r_busy <= 1'b1;
            if (r_count == c_last_a) begin
              r_state <= LOAD_B;
              r_count <= '0;
            end else begin
              r_count <= r_count + c_one;
            end
          end
        end
        LOAD_B: begin
          if (w_accept) begin
            r_mat2[int'(r_count)*c_fw +: c_fw] <= in_data;
            if (r_count == c_last_b) begin
              r_state     <= FULL;
              r_count     <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_count <= r_count + c_one;
            end
          end
        end
        FULL: begin
          if (w_handshake) begin
            r_state     <= LOAD_A;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= LOAD_A;
          r_count     <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAT_LOADER_NAN_FLAG_EN
  // Quiet or signalling NaN: exponent all ones with a nonzero mantissa
  function automatic logic is_nan(input logic [c_fw-1:0] w);
    return (&w[c_fw-2 -: EXP_WIDTH]) && (|w[MAN_WIDTH-1:0]);
  endfunction

  logic r_nan;

  // Sticky NaN flag covering the pair currently being loaded or held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nan <= 1'b0;
    end else if (clear || w_handshake) begin
      r_nan <= 1'b0;
    end else if (w_accept && is_nan(in_data)) begin
      r_nan <= 1'b1;
    end
  end

  assign nan_seen = r_nan;
`endif

endmodule

`default_nettype wire
